// File: rtl/watchdog_heartbeat_source_if.sv
// Watchdog link bundle: liveness/enable/force_reset into the heartbeat source,
// heartbeat and status back out.
interface watchdog_heartbeat_source_if #(
  parameter int unsigned N_SRC = 4
);
  logic             enable;
  logic [N_SRC-1:0] alive;
  logic             force_reset;
  logic             heartbeat;
  logic [N_SRC-1:0] missed_mask;
  logic [7:0]       miss_count;
  logic [15:0]      hb_count;
  logic [2:0]       state;

  // Heartbeat source side
  modport master (
    input  enable,
    input  alive,
    input  force_reset,
    output heartbeat,
    output missed_mask,
    output miss_count,
    output hb_count,
    output state
  );

  // Watchdog / supervisor side
  modport slave (
    output enable,
    output alive,
    output force_reset,
    input  heartbeat,
    input  missed_mask,
    input  miss_count,
    input  hb_count,
    input  state
  );
endinterface

// File: rtl/watchdog_heartbeat_source.sv
// Watchdog heartbeat source: emits a heartbeat pulse only when every monitored
// source strobed alive within the collection window; records missing sources
// and holds off after a watchdog-forced reset.
module watchdog_heartbeat_source #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned WINDOW    = 1000,
  parameter int unsigned PULSE_LEN = 1,
  parameter int unsigned HOLDOFF   = 16
) (
  input logic                   clk,
  input logic                   rst,
  watchdog_heartbeat_source_if.master bus
);

  localparam int unsigned WinW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned PulseW = $clog2(PULSE_LEN + 1);
  localparam int unsigned HoldW  = $clog2(HOLDOFF + 1);

  localparam logic [WinW-1:0]   WinLast   = WinW'(WINDOW - 1);
  localparam logic [PulseW-1:0] PulseLoad = PulseW'(PULSE_LEN);
  localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HOLDOFF);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StEmit    = 3'd2,
    StMiss    = 3'd3,
    StRecover = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  seen_q, seen_d;
  logic [WinW-1:0]   win_cnt_q, win_cnt_d;
  logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [HoldW-1:0]  holdoff_q, holdoff_d;
  logic              heartbeat_q, heartbeat_d;
  logic [N_SRC-1:0]  missed_mask_q, missed_mask_d;
  logic [7:0]        miss_count_q, miss_count_d;
  logic [15:0]       hb_count_q, hb_count_d;
  logic [N_SRC-1:0]  seen_now;

  // Include this cycle's strobes so a strobe on the evaluation cycle counts
  assign seen_now = seen_q | bus.alive;

  // Next-state, window bookkeeping and status updates
  always_comb begin
    state_d       = state_q;
    seen_d        = seen_q;
    win_cnt_d     = win_cnt_q;
    pulse_cnt_d   = pulse_cnt_q;
    holdoff_d     = holdoff_q;
    missed_mask_d = missed_mask_q;
    miss_count_d  = miss_count_q;
    hb_count_d    = hb_count_q;

    if (!bus.enable) begin
      state_d     = StIdle;
      seen_d      = '0;
      win_cnt_d   = '0;
      pulse_cnt_d = '0;
      holdoff_d   = '0;
    end else if (bus.force_reset && (state_q != StIdle)) begin
      // Truncates any pulse in progress; a repeat during RECOVER reloads
      state_d     = StRecover;
      holdoff_d   = HoldLoad;
      seen_d      = '0;
      win_cnt_d   = '0;
      pulse_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StCollect;
          seen_d    = '0;
          win_cnt_d = '0;
        end
        StCollect: begin
          if (win_cnt_q == WinLast) begin
            seen_d    = '0;
            win_cnt_d = '0;
            if (&seen_now) begin
              state_d       = StEmit;
              pulse_cnt_d   = PulseLoad;
              hb_count_d    = hb_count_q + 16'd1;
              missed_mask_d = '0;
            end else begin
              state_d       = StMiss;
              missed_mask_d = ~seen_now;
              if (miss_count_q != 8'hFF) begin
                miss_count_d = miss_count_q + 8'd1;
              end
            end
          end else begin
            seen_d    = seen_now;
            win_cnt_d = win_cnt_q + WinW'(1);
          end
        end
        StEmit: begin
          // alive ignored here: the next window starts clean
          if (pulse_cnt_q <= PulseW'(1)) begin
            state_d     = StCollect;
            pulse_cnt_d = '0;
            seen_d      = '0;
            win_cnt_d   = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q - PulseW'(1);
          end
        end
        StMiss: begin
          state_d   = StCollect;
          seen_d    = '0;
          win_cnt_d = '0;
        end
        StRecover: begin
          if (holdoff_q <= HoldW'(1)) begin
            state_d   = StCollect;
            holdoff_d = '0;
            seen_d    = '0;
            win_cnt_d = '0;
          end else begin
            holdoff_d = holdoff_q - HoldW'(1);
          end
        end
        default: begin
          state_d   = StIdle;
          seen_d    = '0;
          win_cnt_d = '0;
        end
      endcase
    end

    // Registered heartbeat mirrors the upcoming EMIT state
    heartbeat_d = (state_d == StEmit);
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      seen_q        <= '0;
      win_cnt_q     <= '0;
      pulse_cnt_q   <= '0;
      holdoff_q     <= '0;
      heartbeat_q   <= 1'b0;
      missed_mask_q <= '0;
      miss_count_q  <= '0;
      hb_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      seen_q        <= seen_d;
      win_cnt_q     <= win_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      holdoff_q     <= holdoff_d;
      heartbeat_q   <= heartbeat_d;
      missed_mask_q <= missed_mask_d;
      miss_count_q  <= miss_count_d;
      hb_count_q    <= hb_count_d;
    end
  end

  assign bus.heartbeat   = heartbeat_q;
  assign bus.missed_mask = missed_mask_q;
  assign bus.miss_count  = miss_count_q;
  assign bus.hb_count    = hb_count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_watchdog_heartbeat_source.sv
// Directed bench for watchdog_heartbeat_source (N_SRC=4, WINDOW=8,
// PULSE_LEN=2, HOLDOFF=4). Inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_watchdog_heartbeat_source;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  watchdog_heartbeat_source_if #(.N_SRC(4)) bus ();

  watchdog_heartbeat_source #(
    .N_SRC     (4),
    .WINDOW    (8),
    .PULSE_LEN (2),
    .HOLDOFF   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.alive = 4'h0;
    bus.force_reset = 1'b0;
    tick();
    tick();
    checks++; if (bus.heartbeat !== 1'b0) begin failures++; $display("FAIL reset_hb act=%b exp=0", bus.heartbeat); end
    checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_state act=%0d exp=0", bus.state); end
    checks++; if (bus.missed_mask !== 4'h0) begin failures++; $display("FAIL reset_mask act=%h exp=0", bus.missed_mask); end
    checks++; if (bus.miss_count !== 8'd0) begin failures++; $display("FAIL reset_miss act=%0d exp=0", bus.miss_count); end
    checks++; if (bus.hb_count !== 16'd0) begin failures++; $display("FAIL reset_hbcnt act=%0d exp=0", bus.hb_count); end
    rst = 1'b0;
  endtask

  // All sources alive every cycle: pulse of 2, period 10
  task automatic test_basic();
    bus.enable = 1'b1;
    bus.alive = 4'hF;
    tick();
    checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL basic_start act=%0d exp=1", bus.state); end
    for (int p = 1; p <= 3; p++) begin
      repeat (7) begin
        tick();
        checks++; if (bus.heartbeat !== 1'b0) begin failures++; $display("FAIL basic_quiet p=%0d act=%b exp=0", p, bus.heartbeat); end
      end
      tick();
      checks++; if (bus.heartbeat !== 1'b1) begin failures++; $display("FAIL basic_rise p=%0d act=%b exp=1", p, bus.heartbeat); end
      checks++; if (bus.hb_count !== 16'(p)) begin failures++; $display("FAIL basic_hbcnt act=%0d exp=%0d", bus.hb_count, p); end
      checks++; if (bus.missed_mask !== 4'h0) begin failures++; $display("FAIL basic_mask act=%h exp=0", bus.missed_mask); end
      tick();
      checks++; if (bus.heartbeat !== 1'b1) begin failures++; $display("FAIL basic_pulse2 p=%0d act=%b exp=1", p, bus.heartbeat); end
      tick();
      checks++; if (bus.heartbeat !== 1'b0 || bus.state !== 3'd1) begin failures++; $display("FAIL basic_fall p=%0d act=%b/%0d exp=0/1", p, bus.heartbeat, bus.state); end
    end
  endtask

  // Source 2 silent: MISS every 9 cycles
  task automatic test_miss();
    bus.alive = 4'b1011;
    for (int p = 1; p <= 3; p++) begin
      repeat (7) begin
        tick();
        checks++; if (bus.heartbeat !== 1'b0 || bus.state !== 3'd1) begin failures++; $display("FAIL miss_collect act=%b/%0d exp=0/1", bus.heartbeat, bus.state); end
      end
      tick();
      checks++; if (bus.state !== 3'd3) begin failures++; $display("FAIL miss_state p=%0d act=%0d exp=3", p, bus.state); end
      checks++; if (bus.missed_mask !== 4'b0100) begin failures++; $display("FAIL miss_mask act=%b exp=0100", bus.missed_mask); end
      checks++; if (bus.miss_count !== 8'(p)) begin failures++; $display("FAIL miss_count act=%0d exp=%0d", bus.miss_count, p); end
      checks++; if (bus.heartbeat !== 1'b0 || bus.hb_count !== 16'd3) begin failures++; $display("FAIL miss_hb act=%b/%0d exp=0/3", bus.heartbeat, bus.hb_count); end
      tick();
      checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL miss_back act=%0d exp=1", bus.state); end
    end
  endtask

  // Single strobes; source 3 on the evaluation cycle, then inside EMIT
  task automatic test_single_strobes();
    logic [3:0] pat_a [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b1000};
    logic [3:0] pat_b [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      bus.alive = pat_a[i];
      tick();
    end
    checks++; if (bus.state !== 3'd2 || bus.heartbeat !== 1'b1) begin failures++; $display("FAIL strobe_emit act=%0d/%b exp=2/1", bus.state, bus.heartbeat); end
    checks++; if (bus.missed_mask !== 4'h0) begin failures++; $display("FAIL strobe_mask_clr act=%b exp=0000", bus.missed_mask); end
    checks++; if (bus.hb_count !== 16'd4) begin failures++; $display("FAIL strobe_hbcnt act=%0d exp=4", bus.hb_count); end
    bus.alive = 4'h0;
    tick();
    bus.alive = 4'b1000;
    tick();
    checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL strobe_collect act=%0d exp=1", bus.state); end
    for (int i = 0; i < 8; i++) begin
      bus.alive = pat_b[i];
      tick();
    end
    checks++; if (bus.state !== 3'd3) begin failures++; $display("FAIL strobe_miss act=%0d exp=3", bus.state); end
    checks++; if (bus.missed_mask !== 4'b1000) begin failures++; $display("FAIL strobe_mask act=%b exp=1000", bus.missed_mask); end
    checks++; if (bus.miss_count !== 8'd4) begin failures++; $display("FAIL strobe_misscnt act=%0d exp=4", bus.miss_count); end
    tick();
  endtask

  // enable low for 3 edges mid-window: IDLE, status held, fresh window
  task automatic test_enable_drop();
    bus.alive = 4'hF;
    repeat (3) tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.state !== 3'd0 || bus.heartbeat !== 1'b0) begin failures++; $display("FAIL drop_idle act=%0d/%b exp=0/0", bus.state, bus.heartbeat); end
      checks++; if (bus.missed_mask !== 4'b1000 || bus.miss_count !== 8'd4 || bus.hb_count !== 16'd4) begin failures++; $display("FAIL drop_hold act=%b/%0d/%0d exp=1000/4/4", bus.missed_mask, bus.miss_count, bus.hb_count); end
    end
    bus.enable = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL drop_resume act=%0d exp=1", bus.state); end
    repeat (7) begin
      tick();
      checks++; if (bus.heartbeat !== 1'b0) begin failures++; $display("FAIL drop_early act=%b exp=0", bus.heartbeat); end
    end
    tick();
    checks++; if (bus.heartbeat !== 1'b1 || bus.hb_count !== 16'd5) begin failures++; $display("FAIL drop_emit act=%b/%0d exp=1/5", bus.heartbeat, bus.hb_count); end
    tick();
    tick();
  endtask

  // force_reset on first EMIT cycle, retrigger 2 cycles into RECOVER
  task automatic test_force_reset();
    bus.alive = 4'hF;
    repeat (7) tick();
    tick();
    checks++; if (bus.state !== 3'd2 || bus.hb_count !== 16'd6) begin failures++; $display("FAIL force_pre act=%0d/%0d exp=2/6", bus.state, bus.hb_count); end
    bus.force_reset = 1'b1;
    tick();
    bus.force_reset = 1'b0;
    checks++; if (bus.heartbeat !== 1'b0 || bus.state !== 3'd4) begin failures++; $display("FAIL force_trunc act=%b/%0d exp=0/4", bus.heartbeat, bus.state); end
    checks++; if (bus.hb_count !== 16'd6 || bus.miss_count !== 8'd4) begin failures++; $display("FAIL force_hold act=%0d/%0d exp=6/4", bus.hb_count, bus.miss_count); end
    tick();
    checks++; if (bus.state !== 3'd4) begin failures++; $display("FAIL force_rec2 act=%0d exp=4", bus.state); end
    bus.force_reset = 1'b1;
    tick();
    bus.force_reset = 1'b0;
    checks++; if (bus.state !== 3'd4) begin failures++; $display("FAIL force_reload act=%0d exp=4", bus.state); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.state !== 3'd4 || bus.heartbeat !== 1'b0) begin failures++; $display("FAIL force_hold_rec i=%0d act=%0d exp=4", i, bus.state); end
    end
    tick();
    checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL force_exit act=%0d exp=1", bus.state); end
    repeat (7) begin
      tick();
      checks++; if (bus.heartbeat !== 1'b0) begin failures++; $display("FAIL force_early act=%b exp=0", bus.heartbeat); end
    end
    tick();
    checks++; if (bus.heartbeat !== 1'b1 || bus.hb_count !== 16'd7) begin failures++; $display("FAIL force_next_hb act=%b/%0d exp=1/7", bus.heartbeat, bus.hb_count); end
    tick();
    tick();
  endtask

  // No source alive: miss_count climbs from 4 and sticks at 255
  task automatic test_saturation();
    logic [7:0] exp_cnt;
    bus.alive = 4'h0;
    for (int w = 5; w <= 260; w++) begin
      repeat (8) tick();
      exp_cnt = (w > 255) ? 8'd255 : 8'(w);
      checks++; if (bus.state !== 3'd3 || bus.miss_count !== exp_cnt) begin failures++; $display("FAIL sat_count w=%0d act=%0d/%0d exp=3/%0d", w, bus.state, bus.miss_count, exp_cnt); end
      checks++; if (bus.missed_mask !== 4'hF) begin failures++; $display("FAIL sat_mask act=%h exp=f", bus.missed_mask); end
      tick();
    end
  endtask

  // Reset from a busy state with non-zero status
  task automatic test_reset_mid();
    bus.alive = 4'hF;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd0 || bus.heartbeat !== 1'b0) begin failures++; $display("FAIL rstmid_state act=%0d/%b exp=0/0", bus.state, bus.heartbeat); end
    checks++; if (bus.miss_count !== 8'd0 || bus.hb_count !== 16'd0 || bus.missed_mask !== 4'h0) begin failures++; $display("FAIL rstmid_cnt act=%0d/%0d/%h exp=0/0/0", bus.miss_count, bus.hb_count, bus.missed_mask); end
    rst = 1'b0;
    bus.enable = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.alive = 4'h0;
    bus.force_reset = 1'b0;
    test_reset();
    test_basic();
    test_miss();
    test_single_strobes();
    test_enable_drop();
    test_force_reset();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
